// File: rtl/uart_pkg.sv
// Shared state encoding and parameter helpers for the Uart8 transmit arbiter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } tx_state_t;

    // A 10-bit frame plus two bit times of margin before declaring the UART stuck.
    localparam int unsigned FRAME_BIT_TIMES = 12;

    function automatic int unsigned done_timeout(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
        return (clock_rate / baud_rate) * FRAME_BIT_TIMES;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Terminal value of a counter that starts at zero and must span n cycles.
    function automatic int unsigned last_count(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: combinational grant, last winner updated on accept.
module rr_arbiter2 (
    input  logic clk,
    input  logic rstN,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_accept,
    output logic o_any_c,
    output logic o_grant_b_c
);

    logic r_last_b;

    assign o_any_c     = i_req_a | i_req_b;
    // B wins when alone, or on a tie when A owned the previous grant.
    assign o_grant_b_c = i_req_b & (~i_req_a | ~r_last_b);

    // Reset to B so that A takes the first tie.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_last_b <= 1'b1;
        end else if (i_accept) begin
            r_last_b <= o_grant_b_c;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter between two byte requesters, sequencing start,
// busy and done with watchdogs and an inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE    = 12000000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned START_TIMEOUT = 8,
    parameter int unsigned DONE_TIMEOUT  = done_timeout(CLOCK_RATE, BAUD_RATE)
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       enable,
    input  logic       aValid,
    input  logic [7:0] aByte,
    output logic       aReady,
    input  logic       bValid,
    input  logic [7:0] bByte,
    output logic       bReady,
    output logic       txEn,
    output logic       txStart,
    output logic [7:0] txByte,
    input  logic       txBusy,
    input  logic       txDone,
    output logic       busy,
    output logic       grantB,
    output logic       err,
    input  logic       clrErr
);

    localparam int unsigned CNT_MAX = max3(GAP_CYCLES, START_TIMEOUT, DONE_TIMEOUT);
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(last_count(START_TIMEOUT));
    localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(last_count(DONE_TIMEOUT));
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(last_count(GAP_CYCLES));

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_set_err;
    logic             w_any_req;
    logic             w_grant_b;

    logic             r_tx_en;
    logic             r_tx_start;
    logic [7:0]       r_tx_byte;
    logic             r_a_ready;
    logic             r_b_ready;
    logic             r_busy;
    logic             r_grant_b;
    logic             r_err;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rstN        (rstN),
        .i_req_a     (aValid),
        .i_req_b     (bValid),
        .i_accept    (w_accept),
        .o_any_c     (w_any_req),
        .o_grant_b_c (w_grant_b)
    );

    // Saturating increment: the counter never wraps back to zero.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, counter and control decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_any_req) begin
                    w_accept     = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_cnt_next   = '0;
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A done seen before busy means the UART already finished the frame.
                if (txDone) begin
                    w_cnt_next   = '0;
                    w_state_next = GAP;
                end else if (txBusy) begin
                    w_cnt_next   = '0;
                    w_state_next = WAIT_DONE;
                end else if (r_cnt >= START_LAST) begin
                    w_cnt_next   = '0;
                    w_set_err    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (txDone) begin
                    w_cnt_next   = '0;
                    w_state_next = GAP;
                end else if (r_cnt >= DONE_LAST) begin
                    w_cnt_next   = '0;
                    w_set_err    = 1'b1;
                    w_state_next = GAP;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            GAP: begin
                if (r_cnt >= GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, counter and data latch.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt      <= '0;
            r_tx_en    <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_a_ready  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_busy     <= 1'b0;
            r_grant_b  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_tx_en    <= enable;
            r_tx_start <= (r_state == START);
            r_a_ready  <= w_accept & ~w_grant_b;
            r_b_ready  <= w_accept & w_grant_b;
            r_busy     <= (w_state_next != IDLE);
            if (w_accept) begin
                r_tx_byte <= w_grant_b ? bByte : aByte;
                r_grant_b <= w_grant_b;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (clrErr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign aReady  = r_a_ready;
    assign bReady  = r_b_ready;
    assign txEn    = r_tx_en;
    assign txStart = r_tx_start;
    assign txByte  = r_tx_byte;
    assign busy    = r_busy;
    assign grantB  = r_grant_b;
    assign err     = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural Uart8 stand-in, directed scenarios and
// randomized round-robin traffic checked against an arbitration model.
module tb_uart_tx_arbiter;

    localparam int GAP      = 16;
    localparam int DONE_TO  = 15000;
    localparam int BIT_CYC  = 8;
    localparam int M_NORMAL  = 0;
    localparam int M_DEAD    = 1;
    localparam int M_NO_DONE = 2;
    localparam int M_FAST    = 3;

    logic       clk;
    logic       rstN;
    logic       enable;
    logic       aValid;
    logic [7:0] aByte;
    logic       aReady;
    logic       bValid;
    logic [7:0] bByte;
    logic       bReady;
    logic       txEn;
    logic       txStart;
    logic [7:0] txByte;
    logic       txBusy;
    logic       txDone;
    logic       busy;
    logic       grantB;
    logic       err;
    logic       clrErr;

    int n_checks;
    int n_fail;
    int n_ar = 0;
    int n_br = 0;

    uart_tx_arbiter dut (
        .clk     (clk),
        .rstN    (rstN),
        .enable  (enable),
        .aValid  (aValid),
        .aByte   (aByte),
        .aReady  (aReady),
        .bValid  (bValid),
        .bByte   (bByte),
        .bReady  (bReady),
        .txEn    (txEn),
        .txStart (txStart),
        .txByte  (txByte),
        .txBusy  (txBusy),
        .txDone  (txDone),
        .busy    (busy),
        .grantB  (grantB),
        .err     (err),
        .clrErr  (clrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uart8 stand-in: short bit period, mode selects healthy or faulty behaviour.
    int         u_mode;
    logic       u_rst_n;
    logic       u_active;
    logic       u_done;
    logic       u_fast;
    logic [9:0] u_shift;
    logic [9:0] u_bits;
    logic [7:0] u_cap;
    int         u_bit;
    int         u_cyc;
    wire        w_stub_rst_n = rstN & u_rst_n;
    wire        w_line = u_active ? u_shift[0] : 1'b1;

    assign txBusy = u_active;
    assign txDone = u_done;

    always @(posedge clk or negedge w_stub_rst_n) begin
        if (!w_stub_rst_n) begin
            u_active <= 1'b0;
            u_done   <= 1'b0;
            u_fast   <= 1'b0;
            u_shift  <= '1;
            u_bits   <= '0;
            u_bit    <= 0;
            u_cyc    <= 0;
        end else begin
            u_done <= u_fast;
            u_fast <= 1'b0;
            if (!u_active) begin
                if (txStart && txEn && u_mode != M_DEAD) begin
                    u_cap <= txByte;
                    if (u_mode == M_FAST) begin
                        u_fast <= 1'b1;
                    end else begin
                        u_active <= 1'b1;
                        u_shift  <= {1'b1, txByte, 1'b0};
                        u_bits   <= '0;
                        u_bit    <= 0;
                        u_cyc    <= 0;
                    end
                end
            end else if (u_mode != M_NO_DONE) begin
                if (u_cyc == BIT_CYC - 1) begin
                    u_cyc   <= 0;
                    u_bits  <= {w_line, u_bits[9:1]};
                    u_shift <= {1'b1, u_shift[9:1]};
                    u_bit   <= u_bit + 1;
                    if (u_bit == 9) begin
                        u_active <= 1'b0;
                        u_done   <= 1'b1;
                    end
                end else begin
                    u_cyc <= u_cyc + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (aReady === 1'b1) n_ar++;
        if (bReady === 1'b1) n_br++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (aReady !== 1'b1 && bReady !== 1'b1 && i < 64) begin
            tick();
            i++;
        end
        chk({tag, "_ready_seen"}, 32'(aReady | bReady), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (txDone !== 1'b1 && i < 400) begin
            tick();
            i++;
        end
        chk({tag, "_done_seen"}, 32'(txDone), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < 64) begin
            tick();
            i++;
        end
        chk({tag, "_idle_seen"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         k;
        int         ar0;
        int         br0;
        logic       pa;
        logic       pb;
        logic       m_last_b;
        logic       exp_b;
        logic [7:0] exp_byte;
        logic [1:0] sel;

        n_checks = 0;
        n_fail   = 0;
        rstN     = 1'b0;
        enable   = 1'b0;
        aValid   = 1'b0;
        bValid   = 1'b0;
        aByte    = 8'h00;
        bByte    = 8'h00;
        clrErr   = 1'b0;
        u_mode   = M_NORMAL;
        u_rst_n  = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txen", 32'(txEn), 32'd0);
        chk("rst_txbyte", 32'(txByte), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_grantb", 32'(grantB), 32'd0);
        chk("rst_pulses", 32'({aReady, bReady, txStart}), 32'd0);
        rstN   = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        chk("txen_follow", 32'(txEn), 32'd1);

        // Single request from A with byte D5
        ar0    = n_ar;
        aByte  = 8'hD5;
        aValid = 1'b1;
        tick();
        chk("t1_aready", 32'(aReady), 32'd1);
        chk("t1_grantb", 32'(grantB), 32'd0);
        chk("t1_txbyte", 32'(txByte), 32'hD5);
        aValid = 1'b0;
        tick();
        chk("t1_txstart", 32'(txStart), 32'd1);
        chk("t1_aready_off", 32'(aReady), 32'd0);
        wait_done("t1");
        chk("t1_line", 32'(u_bits), 32'({1'b1, 8'hD5, 1'b0}));
        chk("t1_txbyte_held", 32'(txByte), 32'hD5);
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("t1_busy_fall", 32'(k), 32'(GAP + 1));
        chk("t1_aready_count", 32'(n_ar - ar0), 32'd1);

        // Contention after reset: A takes the first tie, then strict alternation
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        ar0    = n_ar;
        br0    = n_br;
        aByte  = 8'h11;
        bByte  = 8'h22;
        aValid = 1'b1;
        bValid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_ready($sformatf("t2_f%0d", f));
            exp_b = 1'(f % 2);
            chk($sformatf("t2_who%0d", f), 32'({aReady, bReady}), exp_b ? 32'd1 : 32'd2);
            chk($sformatf("t2_byte%0d", f), 32'(txByte), exp_b ? 32'h22 : 32'h11);
            if (f == 3) begin
                aValid = 1'b0;
                bValid = 1'b0;
            end
            wait_done($sformatf("t2_f%0d", f));
            chk($sformatf("t2_sent%0d", f), 32'(u_cap), exp_b ? 32'h22 : 32'h11);
            wait_idle($sformatf("t2_f%0d", f));
        end
        chk("t2_a_count", 32'(n_ar - ar0), 32'd2);
        chk("t2_b_count", 32'(n_br - br0), 32'd2);

        // Start timeout, with clear and set landing in the same cycle
        u_mode = M_DEAD;
        aByte  = 8'h5A;
        aValid = 1'b1;
        wait_ready("t3");
        aValid = 1'b0;
        tick();
        chk("t3_txstart", 32'(txStart), 32'd1);
        repeat (7) tick();
        chk("t3_err_early", 32'(err), 32'd0);
        clrErr = 1'b1;
        tick();
        chk("t3_err_set_wins", 32'(err), 32'd1);
        chk("t3_back_idle", 32'(busy), 32'd0);
        tick();
        chk("t3_err_cleared", 32'(err), 32'd0);
        clrErr = 1'b0;

        // Done timeout: UART goes busy and never finishes
        u_mode = M_NO_DONE;
        bByte  = 8'h3C;
        bValid = 1'b1;
        wait_ready("t4");
        chk("t4_bready", 32'(bReady), 32'd1);
        bValid = 1'b0;
        tick();
        chk("t4_txstart", 32'(txStart), 32'd1);
        k = 0;
        while (err !== 1'b1 && k < DONE_TO + 100) begin
            tick();
            k++;
        end
        chk("t4_err_latency", 32'(k), 32'(DONE_TO + 2));
        chk("t4_in_gap", 32'(busy), 32'd1);
        u_rst_n = 1'b0;
        tick();
        u_rst_n = 1'b1;
        u_mode  = M_NORMAL;
        wait_idle("t4_gap");
        aByte  = 8'h96;
        aValid = 1'b1;
        wait_ready("t4_next");
        chk("t4_next_aready", 32'(aReady), 32'd1);
        aValid = 1'b0;
        wait_done("t4_next");
        chk("t4_next_sent", 32'(u_cap), 32'h96);
        chk("t4_err_sticky", 32'(err), 32'd1);
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        chk("t4_err_cleared", 32'(err), 32'd0);
        wait_idle("t4_next");

        // Asynchronous reset in the middle of a B frame
        bByte  = 8'hC3;
        bValid = 1'b1;
        wait_ready("t5");
        bValid = 1'b0;
        repeat (20) tick();
        chk("t5_mid_frame", 32'({busy, txBusy, grantB}), 32'd7);
        #2 rstN = 1'b0;
        #1;
        chk("t5_async_ctrl", 32'({busy, txStart, aReady, bReady, grantB, err, txEn}), 32'd0);
        chk("t5_async_byte", 32'(txByte), 32'd0);
        tick();
        rstN   = 1'b1;
        aByte  = 8'h01;
        bByte  = 8'h02;
        aValid = 1'b1;
        bValid = 1'b1;
        wait_ready("t5_tie");
        chk("t5_tie_to_a", 32'({aReady, bReady}), 32'd2);
        aValid = 1'b0;
        wait_done("t5_a");
        wait_idle("t5_a");
        wait_ready("t5_b");
        chk("t5_then_b", 32'({aReady, bReady}), 32'd1);
        bValid = 1'b0;
        wait_done("t5_b");
        wait_idle("t5_b");

        // Enable gating
        enable = 1'b0;
        tick();
        tick();
        chk("t6_txen_low", 32'(txEn), 32'd0);
        ar0    = n_ar;
        aByte  = 8'h77;
        aValid = 1'b1;
        repeat (5) tick();
        chk("t6_no_ready", 32'(n_ar - ar0), 32'd0);
        chk("t6_still_idle", 32'({aReady, busy, txEn}), 32'd0);
        enable = 1'b1;
        tick();
        chk("t6_txen_high", 32'(txEn), 32'd1);
        chk("t6_aready", 32'(aReady), 32'd1);
        aValid = 1'b0;
        wait_done("t6");
        wait_idle("t6");

        // Randomized traffic against the round-robin model
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        pa       = 1'b0;
        pb       = 1'b0;
        m_last_b = 1'b1;
        for (int r = 0; r < 16; r++) begin
            sel = 2'($urandom_range(1, 3));
            if (!pa && sel[0]) begin
                aByte  = 8'($urandom);
                aValid = 1'b1;
                pa     = 1'b1;
            end
            if (!pb && sel[1]) begin
                bByte  = 8'($urandom);
                bValid = 1'b1;
                pb     = 1'b1;
            end
            u_mode   = ($urandom_range(0, 3) == 0) ? M_FAST : M_NORMAL;
            exp_b    = (pa && pb) ? ~m_last_b : pb;
            exp_byte = exp_b ? bByte : aByte;
            wait_ready($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_who", r), 32'({aReady, bReady}), exp_b ? 32'd1 : 32'd2);
            chk($sformatf("rnd%0d_byte", r), 32'(txByte), 32'(exp_byte));
            chk($sformatf("rnd%0d_grantb", r), 32'(grantB), 32'(exp_b));
            if (exp_b) begin
                bValid = 1'b0;
                pb     = 1'b0;
            end else begin
                aValid = 1'b0;
                pa     = 1'b0;
            end
            m_last_b = exp_b;
            wait_done($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_sent", r), 32'(u_cap), 32'(exp_byte));
            chk($sformatf("rnd%0d_err", r), 32'(err), 32'd0);
            wait_idle($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
